// File: rtl/uart_tx_framed.sv
// Burst UART transmitter that sends up to NUM_WORDS framed words back-to-back with optional parity and 1-2 stop bits.
// Start bit goes out the cycle after accept; s_ready is high only in IDLE, and requests made while busy are dropped.
module uart_tx_framed #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int NUM_WORDS        = 3,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [NUM_WORDS*BITS_PER_WORD-1:0] s_data,
    input  logic [$clog2(NUM_WORDS+1)-1:0]     s_len,
    output logic                               tx,
    output logic                               busy,
    output logic                               done
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam int BW = $clog2(BITS_PER_WORD);
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int LW = $clog2(NUM_WORDS + 1);
    localparam int DW = NUM_WORDS * BITS_PER_WORD;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   clk_cnt, clk_n;
    logic [BW-1:0]   bit_cnt, bit_n;
    logic [WW-1:0]   word_idx, word_n;
    logic [WW-1:0]   last_idx, last_n;
    logic [WW-1:0]   eff_last;
    logic [DW-1:0]   data_q, data_n;
    logic            par_acc, par_n;
    logic            tx_n, busy_n, done_n;
    logic            bit_end;

    assign s_ready = (state == ST_IDLE);
    assign bit_end = (clk_cnt == CLK_LAST);

    // Zero or oversized lengths fall back to a full burst.
    always_comb begin
        if (s_len == '0 || s_len > LW'(NUM_WORDS)) begin
            eff_last = WW'(NUM_WORDS - 1);
        end else begin
            eff_last = WW'(s_len - LW'(1));
        end
    end

    always_comb begin
        state_n = state;
        clk_n   = clk_cnt;
        bit_n   = bit_cnt;
        word_n  = word_idx;
        last_n  = last_idx;
        data_n  = data_q;
        par_n   = par_acc;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;

        if (state == ST_IDLE) begin
            tx_n = 1'b1;
            if (s_valid) begin
                state_n = ST_START;
                tx_n    = 1'b0;
                clk_n   = '0;
                bit_n   = '0;
                word_n  = '0;
                last_n  = eff_last;
                data_n  = s_data;
                par_n   = 1'b0;
                busy_n  = 1'b1;
            end
        end else if (!bit_end) begin
            clk_n = clk_cnt + CW'(1);
        end else begin
            clk_n = '0;
            unique case (state)
                ST_START: begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                    tx_n    = data_q[0];
                end
                // Words sit contiguously in data_q, so one shift per data bit walks the whole burst.
                ST_DATA: begin
                    par_n  = par_acc ^ data_q[0];
                    data_n = data_q >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = ST_PARITY;
                            tx_n    = (PARITY == 2) ? par_n : ~par_n;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                        tx_n  = data_q[1];
                    end
                end
                ST_PARITY: begin
                    state_n = ST_STOP;
                    bit_n   = '0;
                    tx_n    = 1'b1;
                end
                ST_STOP: begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_n = '0;
                        if (word_idx == last_idx) begin
                            state_n = ST_IDLE;
                            tx_n    = 1'b1;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_START;
                            tx_n    = 1'b0;
                            word_n  = word_idx + WW'(1);
                            par_n   = 1'b0;
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                        tx_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    tx_n    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            last_idx <= '0;
            data_q   <= '0;
            par_acc  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_n;
            bit_cnt  <= bit_n;
            word_idx <= word_n;
            last_idx <= last_n;
            data_q   <= data_n;
            par_acc  <= par_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Four transmitter configurations driven from one directed sequence; expected line levels are queued per cycle.
module tb_uart_tx_framed;

    logic        clk = 1'b0;
    logic        rst;
    logic        sv  [4];
    logic        rdy [4];
    logic [23:0] sd  [4];
    logic [1:0]  sl  [4];
    logic        txw [4];
    logic        bsy [4];
    logic        dn  [4];

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    // g0: no parity/1 stop, g1: even/1 stop, g2: odd/1 stop/2 words, g3: no parity/2 stop
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NW = (g == 2) ? 2 : 3;
        uart_tx_framed #(
            .CLOCKS_PER_PULSE(4),
            .BITS_PER_WORD   (8),
            .NUM_WORDS       (NW),
            .PARITY          ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
            .STOP_BITS       ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .s_valid(sv[g]),
            .s_ready(rdy[g]),
            .s_data (sd[g][NW*8-1:0]),
            .s_len  (sl[g]),
            .tx     (txw[g]),
            .busy   (bsy[g]),
            .done   (dn[g])
        );
    end

    function automatic int par_of(int g);
        return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    endfunction

    function automatic int stop_of(int g);
        return (g == 3) ? 2 : 1;
    endfunction

    function automatic int nw_of(int g);
        return (g == 2) ? 2 : 3;
    endfunction

    task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, g, obs, exp);
        end
    endtask

    task automatic push_bit(logic b);
        repeat (4) exp_q.push_back(b);
    endtask

    task automatic push_frame(int g, logic [7:0] w);
        logic p;
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(w[i]);
        if (par_of(g) != 0) begin
            p = ^w;
            if (par_of(g) == 1) p = ~p;
            push_bit(p);
        end
        for (int i = 0; i < stop_of(g); i++) push_bit(1'b1);
    endtask

    task automatic expect_burst(int g, logic [23:0] d, logic [1:0] len);
        int n;
        n = (len == 0 || int'(len) > nw_of(g)) ? nw_of(g) : int'(len);
        for (int k = 0; k < n; k++) push_frame(g, d[k*8 +: 8]);
    endtask

    // Called just after a falling edge; the request is taken on the following rising edge.
    task automatic drive(int g, logic [23:0] d, logic [1:0] len);
        sv[g] = 1'b1;
        sd[g] = d;
        sl[g] = len;
        chk("s_ready_before_accept", g, 32'(rdy[g]), 32'd1);
        expect_burst(g, d, len);
    endtask

    task automatic check_stream(int g, bit hold, logic [23:0] chg_d, logic [1:0] chg_l);
        int i;
        logic e;
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (i == 0) begin
                if (!hold) sv[g] = 1'b0;
                chk("s_ready_while_busy", g, 32'(rdy[g]), 32'd0);
            end
            if (hold && i == 20) begin
                sd[g] = chg_d;
                sl[g] = chg_l;
            end
            e = exp_q.pop_front();
            chk("tx_bit", g, 32'(txw[g]), 32'(e));
            chk("busy_in_burst", g, 32'(bsy[g]), 32'd1);
            i++;
        end
    endtask

    task automatic check_done(int g);
        @(negedge clk);
        chk("done_pulse", g, 32'(dn[g]), 32'd1);
        chk("s_ready_at_done", g, 32'(rdy[g]), 32'd1);
        chk("busy_at_done", g, 32'(bsy[g]), 32'd0);
        chk("tx_idle_at_done", g, 32'(txw[g]), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            sv[g] = 1'b0;
            sd[g] = '0;
            sl[g] = '0;
        end
        #2;
        for (int g = 0; g < 4; g++) begin
            chk("reset_s_ready", g, 32'(rdy[g]), 32'd1);
            chk("reset_tx", g, 32'(txw[g]), 32'd1);
            chk("reset_busy", g, 32'(bsy[g]), 32'd0);
            chk("reset_done", g, 32'(dn[g]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single 0xA5 word, no parity: 40 cycles then done.
        drive(0, 24'h0000A5, 2'd1);
        check_stream(0, 1'b0, '0, '0);
        check_done(0);
        @(negedge clk);
        chk("done_one_cycle", 0, 32'(dn[0]), 32'd0);

        // Parity on 0x07: even gives 1, odd gives 0.
        drive(1, 24'h000007, 2'd1);
        check_stream(1, 1'b0, '0, '0);
        check_done(1);
        drive(2, 24'h000007, 2'd1);
        check_stream(2, 1'b0, '0, '0);
        check_done(2);

        // Three contiguous frames with two stop bits.
        drive(3, 24'h332211, 2'd3);
        check_stream(3, 1'b0, '0, '0);
        check_done(3);
        @(negedge clk);
        chk("done_one_cycle", 3, 32'(dn[3]), 32'd0);

        // Length clamping: zero means full burst, oversize clamps to NUM_WORDS.
        drive(0, 24'h5A3C0F, 2'd0);
        check_stream(0, 1'b0, '0, '0);
        check_done(0);
        drive(2, 24'h00C381, 2'd3);
        check_stream(2, 1'b0, '0, '0);
        check_done(2);

        // Inputs changed mid-burst with s_valid held; next burst taken in the done cycle.
        drive(0, 24'h0096F0, 2'd2);
        check_stream(0, 1'b1, 24'h00003C, 2'd1);
        check_done(0);
        expect_burst(0, 24'h00003C, 2'd1);
        check_stream(0, 1'b0, '0, '0);
        check_done(0);

        // Asynchronous reset during data bit 3 of word 1.
        drive(3, 24'h332211, 2'd3);
        for (int i = 0; i < 62; i++) begin
            @(negedge clk);
            if (i == 0) sv[3] = 1'b0;
            chk("tx_before_reset", 3, 32'(txw[3]), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        #1 rst = 1'b1;
        #1;
        chk("async_reset_tx", 3, 32'(txw[3]), 32'd1);
        chk("async_reset_busy", 3, 32'(bsy[3]), 32'd0);
        chk("async_reset_s_ready", 3, 32'(rdy[3]), 32'd1);
        chk("async_reset_done", 3, 32'(dn[3]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_tx_idle", 3, 32'(txw[3]), 32'd1);
            chk("post_reset_busy", 3, 32'(bsy[3]), 32'd0);
        end
        drive(3, 24'h000081, 2'd1);
        check_stream(3, 1'b0, '0, '0);
        check_done(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
